// File: rtl/turn_ctrl_pkg.sv
// Shared types and widths for the per-turn shot sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package turn_ctrl_pkg;

  localparam int POWER_W = 10;
  localparam int SECS_W  = 6;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_PRESS,
    CHARGE,
    FLIGHT,
    DONE,
    WAIT_END
  } turn_state_t;

  typedef enum logic {
    SHOOTER_DOG,
    SHOOTER_CAT
  } shooter_t;

  // Route the active player's button: local button for the dog, link button for the cat.
  function automatic logic fire_select(input shooter_t shooter,
                                       input logic fire_local,
                                       input logic fire_remote);
    return (shooter == SHOOTER_DOG) ? fire_local : fire_remote;
  endfunction

endpackage

// File: rtl/power_meter.sv
// Ping-pong power meter: counts 0..POWER_MAX and back, one step every POWER_STEP_CYCLES while run is high.
// Latency: power updates on the clock edge that completes a step period; clear takes effect next cycle.
// Backpressure: none; run simply freezes the meter and its step prescaler.
module power_meter
  import turn_ctrl_pkg::*;
#(
  parameter int POWER_MAX         = 100,
  parameter int POWER_STEP_CYCLES = 200_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               run,
  output logic [POWER_W-1:0] power
);

  localparam int STEP_W = (POWER_STEP_CYCLES > 1) ? $clog2(POWER_STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(POWER_STEP_CYCLES - 1);
  localparam logic [POWER_W-1:0] PMAX      = POWER_W'(POWER_MAX);

  logic [STEP_W-1:0] step_cnt;
  logic              up;
  logic              step;

  assign step = (step_cnt == STEP_LAST);

  // Step prescaler and bounded up/down meter; reversal happens on the step that
  // would otherwise leave 0..POWER_MAX, so the meter bounces without overrun.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      power    <= '0;
      step_cnt <= '0;
      up       <= 1'b1;
    end else if (run) begin
      if (step) begin
        step_cnt <= '0;
        if (up) begin
          if (power >= PMAX) begin
            up <= 1'b0;
            if (power != '0) power <= power - 1'b1;
          end else begin
            power <= power + 1'b1;
          end
        end else begin
          if (power == '0) begin
            up <= 1'b1;
            if (PMAX != '0) power <= power + 1'b1;
          end else begin
            power <= power - 1'b1;
          end
        end
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/turn_ctrl.sv
// Per-turn shot sequencer: arms the shooter's button, charges the meter, launches, reports hit and turn end.
// Latency: turn start 1 cycle after next_turn rises; launch 1 cycle after release; hit 1 cycle after
//          proj_done with turn_done one cycle later. Backpressure: none; next_turn low aborts silently.
// Build option: define TURN_TIMEOUT_EN to enable the per-shot seconds countdown and forced launch/forfeit.
module turn_ctrl
  import turn_ctrl_pkg::*;
#(
  parameter int POWER_MAX         = 100,
  parameter int POWER_STEP_CYCLES = 200_000,
  parameter int TICKS_PER_SEC     = 40_000_000,
  parameter int TURN_SECS         = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               next_turn,
  input  logic               dog_turn,
  input  logic               cat_turn,
  input  logic               fire_local,
  input  logic               fire_remote,
  input  logic               proj_done,
  input  logic               proj_hit,
  output logic               launch,
  output logic [POWER_W-1:0] power,
  output logic               charging,
  output logic [SECS_W-1:0]  secs_left,
  output logic               hit_dog,
  output logic               hit_cat,
  output logic               turn_done_dog,
  output logic               turn_done_cat
);

  turn_state_t state;
  shooter_t    shooter;
  logic        next_turn_q;
  logic        fire;
  logic        start;
  logic        abort;
  logic        meter_clear;
  logic        meter_run;
  logic        timeout;

  // A turn is only valid with exactly one shooter flag; both low means game over.
  assign start = (state == IDLE) && next_turn && !next_turn_q && (dog_turn ^ cat_turn);
  assign abort = !next_turn || (!dog_turn && !cat_turn);
  assign fire  = fire_select(shooter, fire_local, fire_remote);

  // Meter is zeroed at turn start and held at zero (direction up) while waiting
  // for the press, so CHARGE always begins from a clean 0.
  assign meter_clear = start || (state == WAIT_PRESS);
  assign meter_run   = (state == CHARGE);

  power_meter #(
    .POWER_MAX        (POWER_MAX),
    .POWER_STEP_CYCLES(POWER_STEP_CYCLES)
  ) u_power_meter (
    .clk  (clk),
    .rst  (rst),
    .clear(meter_clear),
    .run  (meter_run),
    .power(power)
  );

`ifdef TURN_TIMEOUT_EN
  localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);

  logic [TICK_W-1:0] tick_cnt;
  logic              timing;
  logic              sec_tick;

  // The clock only runs while the shooter is expected to act.
  assign timing   = (state == WAIT_PRESS) || (state == CHARGE);
  assign sec_tick = timing && (tick_cnt == TICK_LAST);
  // Timeout coincides with the decrement that lands on zero; an already-zero
  // budget also expires on the next second.
  assign timeout  = sec_tick && (secs_left <= SECS_W'(1));

  // Seconds prescaler and saturating countdown, reloaded at every turn start.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt  <= '0;
      secs_left <= SECS_W'(TURN_SECS);
    end else if (start) begin
      tick_cnt  <= '0;
      secs_left <= SECS_W'(TURN_SECS);
    end else if (timing) begin
      if (sec_tick) begin
        tick_cnt <= '0;
        if (secs_left != '0) secs_left <= secs_left - 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end
`else
  logic cfg_unused;

  // Untimed build: the display shows the full budget and nothing ever expires.
  assign secs_left  = SECS_W'(TURN_SECS);
  assign timeout    = 1'b0;
  assign cfg_unused = ^TICKS_PER_SEC;
`endif

  // Turn sequencer with registered pulse outputs; abort has priority in every
  // active state and suppresses launch, hit and done pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      shooter       <= SHOOTER_DOG;
      next_turn_q   <= 1'b0;
      launch        <= 1'b0;
      charging      <= 1'b0;
      hit_dog       <= 1'b0;
      hit_cat       <= 1'b0;
      turn_done_dog <= 1'b0;
      turn_done_cat <= 1'b0;
    end else begin
      next_turn_q   <= next_turn;
      launch        <= 1'b0;
      hit_dog       <= 1'b0;
      hit_cat       <= 1'b0;
      turn_done_dog <= 1'b0;
      turn_done_cat <= 1'b0;

      case (state)
        IDLE: begin
          charging <= 1'b0;
          if (start) begin
            shooter <= dog_turn ? SHOOTER_DOG : SHOOTER_CAT;
            state   <= ARM;
          end
        end

        // Ignore a button still held over from the previous turn.
        ARM: begin
          if (abort) state <= IDLE;
          else if (!fire) state <= WAIT_PRESS;
        end

        WAIT_PRESS: begin
          if (abort) begin
            state <= IDLE;
          end else if (timeout) begin
            state <= DONE;
          end else if (fire) begin
            charging <= 1'b1;
            state    <= CHARGE;
          end
        end

        // Release and timeout in the same cycle still yield a single launch.
        CHARGE: begin
          if (abort) begin
            charging <= 1'b0;
            state    <= IDLE;
          end else if (!fire || timeout) begin
            launch   <= 1'b1;
            charging <= 1'b0;
            state    <= FLIGHT;
          end
        end

        FLIGHT: begin
          if (abort) begin
            state <= IDLE;
          end else if (proj_done) begin
            hit_cat <= proj_hit && (shooter == SHOOTER_DOG);
            hit_dog <= proj_hit && (shooter == SHOOTER_CAT);
            state   <= DONE;
          end
        end

        DONE: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            turn_done_dog <= (shooter == SHOOTER_DOG);
            turn_done_cat <= (shooter == SHOOTER_CAT);
            state         <= WAIT_END;
          end
        end

        WAIT_END: begin
          if (!next_turn) state <= IDLE;
        end

        default: begin
          charging <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
